eth_xbar_scheduler: RTL and testbench

- Central crossbar scheduler for the 8x8 switch.
- Snoops the serial ingress signals (frame_n, valid_n, di) of all 8 input ports and decodes each packet's 3-bit destination address.
- Arbitrates per output port with round-robin among contending inputs and holds each grant until end-of-packet.
- Drives the crossbar select and busy vectors consumed by the output mux/serializer stage.

---
 rtl/eth_xbar_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_eth_xbar_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_xbar_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_xbar_scheduler: 8x8 crossbar scheduler, round-robin per output port.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module eth_xbar_scheduler #(
  parameter int NPORTS     = 8,
  parameter int PAD_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NPORTS-1:0]     frame_n,
  input  logic [NPORTS-1:0]     valid_n,
  input  logic [NPORTS-1:0]     di,
  output logic [NPORTS-1:0]     in_grant,
  output logic [NPORTS-1:0]     in_drop,
  output logic [NPORTS-1:0]     out_busy,
  output logic [3*NPORTS-1:0]   out_sel
);

  localparam int AW = 3;
  localparam int PW = $clog2(PAD_CYCLES + 1);
  localparam logic [PW-1:0] PAD_LAST = PW'(PAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_REQ  = 3'd2,
    S_XFER = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t          state     [NPORTS];
  state_t          state_nxt [NPORTS];
  logic [AW-1:0]   addr      [NPORTS];
  logic [AW-1:0]   addr_nxt  [NPORTS];
  logic [1:0]      acnt      [NPORTS];
  logic [1:0]      acnt_nxt  [NPORTS];
  logic [PW-1:0]   pcnt      [NPORTS];
  logic [PW-1:0]   pcnt_nxt  [NPORTS];
  logic [AW-1:0]   ptr       [NPORTS];
  logic [AW-1:0]   ptr_nxt   [NPORTS];
  logic [AW-1:0]   sel       [NPORTS];
  logic [AW-1:0]   sel_nxt   [NPORTS];
  logic [NPORTS-1:0] busy_nxt;
  logic [NPORTS-1:0] drop_nxt;
  logic [NPORTS-1:0] won;
  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] last_bit;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      req[i]      = (state[i] == S_REQ) && !frame_n[i];
      last_bit[i] = (state[i] == S_XFER) && frame_n[i] && !valid_n[i];
    end
  end

  // Releases free an output for the next edge only: arbitration looks at the
  // registered busy flag, so a freed output is never re-granted on the same edge.
  always_comb begin
    logic          found;
    logic [AW-1:0] idx;
    found    = 1'b0;
    idx      = '0;
    busy_nxt = out_busy;
    won      = '0;
    for (int o = 0; o < NPORTS; o++) begin
      ptr_nxt[o] = ptr[o];
      sel_nxt[o] = sel[o];
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (last_bit[i]) begin
        busy_nxt[addr[i]] = 1'b0;
        sel_nxt[addr[i]]  = '0;
      end
    end
    for (int o = 0; o < NPORTS; o++) begin
      found = 1'b0;
      if (!out_busy[o]) begin
        for (int k = 1; k <= NPORTS; k++) begin
          idx = ptr[o] + AW'(k);
          if (!found && req[idx] && (addr[idx] == AW'(o))) begin
            found       = 1'b1;
            ptr_nxt[o]  = idx;
            sel_nxt[o]  = idx;
            busy_nxt[o] = 1'b1;
            won[idx]    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      state_nxt[i] = state[i];
      addr_nxt[i]  = addr[i];
      acnt_nxt[i]  = acnt[i];
      pcnt_nxt[i]  = pcnt[i];
      drop_nxt[i]  = 1'b0;
      case (state[i])
        S_IDLE: begin
          if (!frame_n[i]) begin
            addr_nxt[i]  = {2'b00, di[i]};
            acnt_nxt[i]  = 2'd1;
            state_nxt[i] = S_ADDR;
          end
        end
        S_ADDR: begin
          if (frame_n[i]) begin
            state_nxt[i] = S_IDLE;
          end else begin
            addr_nxt[i][acnt[i]] = di[i];
            if (acnt[i] == 2'd2) begin
              state_nxt[i] = S_REQ;
              pcnt_nxt[i]  = '0;
            end else begin
              acnt_nxt[i] = acnt[i] + 2'd1;
            end
          end
        end
        S_REQ: begin
          if (frame_n[i]) begin
            state_nxt[i] = S_IDLE;
          end else if (won[i]) begin
            state_nxt[i] = S_XFER;
          end else if (pcnt[i] == PAD_LAST) begin
            state_nxt[i] = S_DROP;
            drop_nxt[i]  = 1'b1;
          end else begin
            pcnt_nxt[i] = pcnt[i] + PW'(1);
          end
        end
        S_XFER: begin
          if (last_bit[i]) state_nxt[i] = S_IDLE;
        end
        S_DROP: begin
          if (frame_n[i]) state_nxt[i] = S_IDLE;
        end
        default: state_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_grant <= '0;
      in_drop  <= '0;
      out_busy <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        state[i] <= S_IDLE;
        addr[i]  <= '0;
        acnt[i]  <= '0;
        pcnt[i]  <= '0;
        ptr[i]   <= AW'(NPORTS - 1);
        sel[i]   <= '0;
      end
    end else begin
      in_drop  <= drop_nxt;
      out_busy <= busy_nxt;
      for (int i = 0; i < NPORTS; i++) begin
        state[i]    <= state_nxt[i];
        addr[i]     <= addr_nxt[i];
        acnt[i]     <= acnt_nxt[i];
        pcnt[i]     <= pcnt_nxt[i];
        ptr[i]      <= ptr_nxt[i];
        sel[i]      <= sel_nxt[i];
        in_grant[i] <= (state_nxt[i] == S_XFER);
      end
    end
  end

  generate
    for (genvar o = 0; o < NPORTS; o++) begin : g_sel
      assign out_sel[3*o +: 3] = sel[o];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_eth_xbar_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_eth_xbar_scheduler: scoreboard bench for the crossbar scheduler.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_eth_xbar_scheduler;
  localparam int NP  = 8;
  localparam int PAD = 5;
  localparam int K_GNT = 1, K_REL = 2, K_DROP = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NP-1:0] frame_n, valid_n, di;
  logic [NP-1:0] in_grant, in_drop, out_busy;
  logic [3*NP-1:0] out_sel;

  eth_xbar_scheduler #(.NPORTS(NP), .PAD_CYCLES(PAD)) dut (
    .clk(clk), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n), .di(di),
    .in_grant(in_grant), .in_drop(in_drop), .out_busy(out_busy), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int t0      = 0;
  bit mon_en  = 1'b0;

  logic [2:0]  fq [NP][$];     // {frame_n, valid_n, di} per cycle
  bit          rq [$];         // reset_n per cycle
  logic [31:0] exp_q [NP][$];  // {kind, output, cycle}
  int          snap_cyc [$];
  logic [47:0] snap_val [$];   // {in_grant, in_drop, out_busy, out_sel}

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic add_frame(input int i, input int start, input int a, input int nbits, input bit term);
    logic [2:0] av;
    av = 3'(a);
    while (fq[i].size() < start) fq[i].push_back(3'b110);
    for (int k = 0; k < 3; k++) fq[i].push_back({1'b0, 1'b1, av[k]});
    for (int k = 0; k < PAD; k++) fq[i].push_back(3'b010);
    for (int k = 0; k < nbits; k++)
      fq[i].push_back({(term && k == nbits - 1), 1'b0, 1'($urandom)});
  endtask

  task automatic ev(input int i, input int kind, input int o, input int rel);
    exp_q[i].push_back({8'(kind), 8'(o), 16'(t0 + rel)});
  endtask

  task automatic snap(input int rel, input logic [47:0] v);
    snap_cyc.push_back(t0 + rel);
    snap_val.push_back(v);
  endtask

  function automatic bit stim_pending();
    bit p;
    p = (rq.size() > 0);
    for (int i = 0; i < NP; i++) if (fq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic begin_scn();
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (stim_pending() && g < 2000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 2000) chk("drain_timeout", 64'd1, 64'd0);
    repeat (6) @(posedge clk);
  endtask

  // Driver: one queue entry per input per cycle, applied mid-cycle.
  initial begin
    logic [2:0] e;
    reset_n = 1'b0;
    frame_n = '1;
    valid_n = '1;
    di      = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        e = (fq[i].size() > 0) ? fq[i].pop_front() : 3'b110;
        frame_n[i] = e[2];
        valid_n[i] = e[1];
        di[i]      = e[0];
      end
      reset_n = (rq.size() > 0) ? rq.pop_front() : 1'b1;
    end
  end

  // Monitor: turns output activity into events and compares against the scoreboard.
  initial begin
    logic [7:0]  held [NP];
    bit          pg   [NP];
    logic [31:0] got;
    logic [7:0]  fo;
    for (int i = 0; i < NP; i++) begin
      held[i] = 8'hFF;
      pg[i]   = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < NP; i++) begin
          if (in_grant[i] === 1'b1 && !pg[i]) begin
            fo = 8'hFF;
            for (int o = 0; o < NP; o++)
              if (out_busy[o] && out_sel[3*o +: 3] == 3'(i)) fo = 8'(o);
            held[i] = fo;
            got = {8'(K_GNT), fo, 16'(cyc)};
            if (exp_q[i].size() == 0) chk($sformatf("unexpected_grant_in%0d", i), {32'd0, got}, 64'd0);
            else chk($sformatf("grant_in%0d", i), {32'd0, got}, {32'd0, exp_q[i].pop_front()});
          end
          if (in_grant[i] === 1'b0 && pg[i]) begin
            fo = held[i];
            if (fo > 8'd7 || out_busy[fo[2:0]] || out_sel[3*fo[2:0] +: 3] != 3'd0) fo = 8'hEE;
            got = {8'(K_REL), fo, 16'(cyc)};
            if (exp_q[i].size() == 0) chk($sformatf("unexpected_release_in%0d", i), {32'd0, got}, 64'd0);
            else chk($sformatf("release_in%0d", i), {32'd0, got}, {32'd0, exp_q[i].pop_front()});
          end
          if (in_drop[i] === 1'b1) begin
            got = {8'(K_DROP), 8'(in_grant[i]), 16'(cyc)};
            if (exp_q[i].size() == 0) chk($sformatf("unexpected_drop_in%0d", i), {32'd0, got}, 64'd0);
            else chk($sformatf("drop_in%0d", i), {32'd0, got}, {32'd0, exp_q[i].pop_front()});
          end
          pg[i] = (in_grant[i] === 1'b1);
        end
        if (snap_cyc.size() > 0 && snap_cyc[0] == cyc) begin
          void'(snap_cyc.pop_front());
          chk("snapshot", {16'd0, in_grant, in_drop, out_busy, out_sel}, {16'd0, snap_val.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [23:0] sel_exp;
    mon_en = 1'b1;

    // Power-on reset: everything idle.
    begin_scn();
    rq.push_back(1'b0);
    rq.push_back(1'b0);
    snap(2, 48'd0);
    drain();

    // Inputs 1 and 6 contend for output 3 right after reset.
    begin_scn();
    add_frame(1, 0, 3, 16, 1'b1);
    add_frame(6, 0, 3, 16, 1'b1);
    ev(1, K_GNT, 3, 4);
    ev(6, K_DROP, 0, 8);
    ev(1, K_REL, 3, 24);
    drain();

    // Input 1 holds output 3; 0, 4, 6 wait; pointer 1 -> input 4 wins.
    begin_scn();
    add_frame(1, 0, 3, 4, 1'b1);
    add_frame(0, 6, 3, 4, 1'b1);
    add_frame(4, 6, 3, 4, 1'b1);
    add_frame(6, 6, 3, 4, 1'b1);
    ev(1, K_GNT, 3, 4);
    ev(1, K_REL, 3, 12);
    ev(4, K_GNT, 3, 13);
    ev(0, K_DROP, 0, 14);
    ev(6, K_DROP, 0, 14);
    ev(4, K_REL, 3, 18);
    drain();

    // Pointer 4: 0 and 6 contend -> 6 wins.
    begin_scn();
    add_frame(0, 0, 3, 8, 1'b1);
    add_frame(6, 0, 3, 8, 1'b1);
    ev(6, K_GNT, 3, 4);
    ev(0, K_DROP, 0, 8);
    ev(6, K_REL, 3, 16);
    drain();

    // Pointer 6: 0 and 6 contend -> 0 wins.
    begin_scn();
    add_frame(0, 0, 3, 8, 1'b1);
    add_frame(6, 0, 3, 8, 1'b1);
    ev(0, K_GNT, 3, 4);
    ev(6, K_DROP, 0, 8);
    ev(0, K_REL, 3, 16);
    drain();

    // Uncontended 4-byte packet, input 2 -> output 5.
    begin_scn();
    add_frame(2, 0, 5, 32, 1'b1);
    ev(2, K_GNT, 5, 4);
    ev(2, K_REL, 5, 40);
    drain();

    // All eight inputs to mirrored outputs at once.
    begin_scn();
    sel_exp = '0;
    for (int i = 0; i < NP; i++) begin
      add_frame(i, 0, 7 - i, 4, 1'b1);
      ev(i, K_GNT, 7 - i, 4);
      ev(i, K_REL, 7 - i, 12);
      sel_exp[3*(7-i) +: 3] = 3'(i);
    end
    snap(4, {8'hFF, 8'h00, 8'hFF, sel_exp});
    drain();

    // Input 3 aborts after two address bits, then a clean frame to output 6.
    begin_scn();
    fq[3].push_back(3'b011);
    fq[3].push_back(3'b010);
    fq[3].push_back(3'b110);
    add_frame(3, 3, 6, 4, 1'b1);
    snap(4, 48'd0);
    ev(3, K_GNT, 6, 7);
    ev(3, K_REL, 6, 15);
    drain();

    // Reset during input 5's payload on output 2, then a fresh frame.
    begin_scn();
    add_frame(5, 0, 2, 5, 1'b0);
    while (rq.size() < 12) rq.push_back(1'b1);
    rq.push_back(1'b0);
    add_frame(5, 16, 2, 4, 1'b1);
    ev(5, K_GNT, 2, 4);
    ev(5, K_REL, 2, 13);
    snap(13, 48'd0);
    ev(5, K_GNT, 2, 20);
    ev(5, K_REL, 2, 28);
    drain();

    for (int i = 0; i < NP; i++)
      chk($sformatf("pending_events_in%0d", i), 64'(exp_q[i].size()), 64'd0);
    chk("pending_snapshots", 64'(snap_cyc.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
